fifo_stream_reader: RTL and testbench

//  Read-side drain for the synchronous fifo: issues o_fifo_rd_en, absorbs the fifo_mem read latency, and

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_stream_buf.sv | 79 +++++++
 rtl/fifo_stream_reader.sv | 95 +++++++++
 tb/tb_fifo_stream_reader.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous fifo and its stream read-side drain.
package fifo_pkg;

  // Deepest fifo_mem read pipeline supported by the read-side logic.
  localparam int MaxReadLatency = 2;

  // Bits needed to hold a count in the range 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_buf.sv
// Small register buffer between the fifo read port and the output stream.
// Pointers wrap explicitly so Depth does not have to be a power of two; the
// head entry is presented combinationally with no extra read latency.
module fifo_stream_buf
  import fifo_pkg::*;
#(
  parameter  int DataWidth = 8,
  parameter  int Depth     = 2,
  localparam int PtrW      = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int LevelW    = level_width(Depth)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_wr_en,
  input  logic [DataWidth-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [DataWidth-1:0] o_rd_data,
  output logic [LevelW-1:0]    o_level
);

  localparam logic [PtrW-1:0]   LastPtr   = PtrW'(Depth - 1);
  localparam logic [LevelW-1:0] FullLevel = LevelW'(Depth);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [LevelW-1:0]    level;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Storage and write pointer; reset also zeroes the entries so the
  // presented word reads as zero out of reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (i_clear) begin
      wr_ptr <= '0;
    end else if (i_wr_en) begin
      mem[wr_ptr] <= i_wr_data;
      wr_ptr      <= ptr_inc(wr_ptr);
    end
  end

  // Read pointer and occupancy; a simultaneous write and read leaves the
  // level unchanged while both pointers move on.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (i_rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({i_wr_en, i_rd_en})
        2'b10:   level <= level + LevelW'(1);
        2'b01:   level <= level - LevelW'(1);
        default: level <= level;
      endcase
    end
  end

  // The credit logic upstream must never write a full buffer or read an empty one.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clear) begin
      assert (!(i_wr_en && !i_rd_en && (level == FullLevel)));
      assert (!(i_rd_en && (level == '0)));
    end
  end

  assign o_rd_data = mem[rd_ptr];
  assign o_level   = level;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain for the synchronous fifo. Pops the fifo only when the
// output buffer is guaranteed room for every word already requested, absorbs
// the fifo_mem read latency with a shift register of past pops, and presents
// the buffered words as a valid/ready stream.
//
// Stream handshake: o_valid is high whenever a word is buffered and o_data is
// that word; a transfer happens on every clock edge where o_valid && i_ready.
// While o_valid && !i_ready both o_valid and o_data hold. o_valid never
// depends combinationally on i_ready.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter  int DataWidth   = 8,
  parameter  int ReadLatency = 1,   // 1..MaxReadLatency
  localparam int BufDepth    = ReadLatency + 1,
  localparam int LevelW      = level_width(BufDepth)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fifo_empty,
  input  logic [DataWidth-1:0] i_fifo_rd_data,
  output logic                 o_fifo_rd_en,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [DataWidth-1:0] o_data,
  input  logic                 i_ready,
  output logic [LevelW-1:0]    o_level
);

  // Wide enough for level + inflight without wrapping.
  localparam int CntW = LevelW + 2;

  logic [ReadLatency-1:0] rd_pipe;   // bit i set: a pop issued i+1 cycles ago
  logic [CntW-1:0]        inflight;
  logic [CntW-1:0]        committed;
  logic [LevelW-1:0]      level;
  logic                   pop;
  logic                   capture;
  logic                   buf_rd;
  logic                   rd_en;

  // Count requested words whose data has not yet been written to the buffer.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ReadLatency; i++) begin
      inflight = inflight + CntW'(rd_pipe[i]);
    end
  end

  assign o_valid   = (level != '0);
  assign pop       = o_valid && i_ready;

  // Slots already spoken for after this cycle's transfer; a new pop is only
  // allowed when one is still free, so the buffer can never overflow.
  assign committed = CntW'(level) + inflight - CntW'(pop);
  assign rd_en     = !i_fifo_empty && !i_flush && i_rst_n &&
                     (committed < CntW'(BufDepth));

  // The oldest pipe bit marks the cycle the fifo data is valid; a flush in
  // that same cycle drops it.
  assign capture   = rd_pipe[ReadLatency-1] && !i_flush;
  assign buf_rd    = pop && !i_flush;

  // Track outstanding fifo reads; flush and reset forget them all.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | ReadLatency'(rd_en);
    end
  end

  // The read pipeline depth must be one the credit scheme was sized for.
  always_ff @(posedge i_clk) begin
    assert ((ReadLatency >= 1) && (ReadLatency <= MaxReadLatency));
  end

  fifo_stream_buf #(
    .DataWidth (DataWidth),
    .Depth     (BufDepth)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_flush),
    .i_wr_en   (capture),
    .i_wr_data (i_fifo_rd_data),
    .i_rd_en   (buf_rd),
    .o_rd_data (o_data),
    .o_level   (level)
  );

  assign o_fifo_rd_en = rd_en;
  assign o_level      = level;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: one instance with ReadLatency=1 and one with
// ReadLatency=2, each fed by a small behavioural fifo whose read data appears
// ReadLatency clocks after the pop.
module tb_fifo_stream_reader;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];

  // ---------------- instance 1: ReadLatency = 1 ----------------
  logic         empty1, rd_en1, valid1;
  logic         flush1 = 1'b0;
  logic         ready1 = 1'b0;
  logic [W-1:0] rdata1, data1;
  logic [1:0]   level1;

  logic [W-1:0] mem1 [256];
  int           wr1 = 0;
  int           rd1 = 0;
  logic [W-1:0] s1_0;

  assign empty1 = (wr1 == rd1);
  assign rdata1 = s1_0;
  always @(posedge clk) begin
    if (rd_en1) begin
      s1_0 <= mem1[8'(rd1)];
      rd1  <= rd1 + 1;
    end
  end

  fifo_stream_reader #(.DataWidth(W), .ReadLatency(1)) dut1 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_fifo_empty   (empty1),
    .i_fifo_rd_data (rdata1),
    .o_fifo_rd_en   (rd_en1),
    .i_flush        (flush1),
    .o_valid        (valid1),
    .o_data         (data1),
    .i_ready        (ready1),
    .o_level        (level1)
  );

  // ---------------- instance 2: ReadLatency = 2 ----------------
  logic         empty2, rd_en2, valid2;
  logic         flush2 = 1'b0;
  logic         ready2 = 1'b0;
  logic [W-1:0] rdata2, data2;
  logic [1:0]   level2;

  logic [W-1:0] mem2 [256];
  int           wr2 = 0;
  int           rd2 = 0;
  logic [W-1:0] s2_0, s2_1;

  assign empty2 = (wr2 == rd2);
  assign rdata2 = s2_1;
  always @(posedge clk) begin
    s2_1 <= s2_0;
    if (rd_en2) begin
      s2_0 <= mem2[8'(rd2)];
      rd2  <= rd2 + 1;
    end
  end

  fifo_stream_reader #(.DataWidth(W), .ReadLatency(2)) dut2 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_fifo_empty   (empty2),
    .i_fifo_rd_data (rdata2),
    .o_fifo_rd_en   (rd_en2),
    .i_flush        (flush2),
    .o_valid        (valid2),
    .o_data         (data2),
    .i_ready        (ready2),
    .o_level        (level2)
  );

  // ---------------- driver tasks ----------------
  task automatic push1(input logic [W-1:0] v);
    mem1[8'(wr1)] = v;
    wr1++;
    exp_q.push_back(v);
  endtask

  task automatic push2(input logic [W-1:0] v);
    mem2[8'(wr2)] = v;
    wr2++;
    exp2_q.push_back(v);
  endtask

  // ---------------- scoreboards ----------------
  task automatic sb1();
    logic [W-1:0] e;
    checks++;
    if (level1 > 2'd2) begin
      errors++;
      $display("FAIL level1_bound: level=%0d max=2", level1);
    end
    if (valid1 && ready1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb1_extra: got %h, expected no word", data1);
      end else begin
        e = exp_q.pop_front();
        if (data1 !== e) begin
          errors++;
          $display("FAIL sb1_data: got %h expected %h", data1, e);
        end
      end
    end
  endtask

  task automatic sb2();
    logic [W-1:0] e;
    checks++;
    if (level2 > 2'd3) begin
      errors++;
      $display("FAIL level2_bound: level=%0d max=3", level2);
    end
    if (valid2 && ready2) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL sb2_extra: got %h, expected no word", data2);
      end else begin
        e = exp2_q.pop_front();
        if (data2 !== e) begin
          errors++;
          $display("FAIL sb2_data: got %h expected %h", data2, e);
        end
      end
    end
  endtask

  // Run until every expected word has been seen; alt toggles i_ready each clk.
  task automatic drain1(input int budget, input bit alt);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      ready1 = alt ? ~ready1 : 1'b1;
      #1;
      sb1();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain1_timeout: %0d words left, expected 0", exp_q.size());
    end
  endtask

  task automatic idle1(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ready1 = 1'b1;
      #1;
      sb1();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({valid1, level1, data1, rd_en1} !== {1'b0, 2'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset1: valid=%b level=%0d data=%h rd_en=%b, required 0/0/00/0",
               valid1, level1, data1, rd_en1);
    end
    checks++;
    if ({valid2, level2, data2, rd_en2} !== {1'b0, 2'd0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset2: valid=%b level=%0d data=%h rd_en=%b, required 0/0/00/0",
               valid2, level2, data2, rd_en2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    @(negedge clk);
    ready1 = 1'b1;
    for (int i = 0; i < 8; i++) push1(8'h10 + 8'(i));
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      checks++;
      if (rd_en1 !== (c < 8)) begin
        errors++;
        $display("FAIL burst_rd_en c=%0d: got %b expected %b", c, rd_en1, (c < 8));
      end
      checks++;
      if (valid1 !== (c >= 2 && c <= 9)) begin
        errors++;
        $display("FAIL burst_valid c=%0d: got %b expected %b", c, valid1, (c >= 2 && c <= 9));
      end
      sb1();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_left: %0d words undelivered, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int pops = 0;
    @(negedge clk);
    ready1 = 1'b0;
    for (int i = 0; i < 8; i++) push1(8'h10 + 8'(i));
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (rd_en1) pops++;
      sb1();
      if (c >= 2) begin
        checks++;
        if ({valid1, data1} !== {1'b1, 8'h10}) begin
          errors++;
          $display("FAIL stall_hold c=%0d: valid=%b data=%h required 1/10", c, valid1, data1);
        end
      end
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("FAIL stall_pops: got %0d expected 2", pops);
    end
    checks++;
    if (level1 !== 2'd2) begin
      errors++;
      $display("FAIL stall_level: got %0d expected 2", level1);
    end
    drain1(40, 1'b0);
    idle1(3);
  endtask

  task automatic test_alternate();
    @(negedge clk);
    ready1 = 1'b1;
    for (int i = 0; i < 32; i++) push1(8'($urandom_range(0, 255)));
    drain1(200, 1'b1);
    idle1(3);
  endtask

  task automatic test_flush();
    // c0: two words, sink stalled
    @(negedge clk);
    ready1 = 1'b0;
    push1(8'hA0);
    push1(8'hA1);
    #1;
    sb1();
    repeat (2) begin
      @(negedge clk);
      #1;
      sb1();
    end
    // c3: buffer full; transfer frees a slot and a new read is issued
    @(negedge clk);
    push1(8'hA2);
    push1(8'hA3);
    ready1 = 1'b1;
    #1;
    checks++;
    if (level1 !== 2'd2) begin
      errors++;
      $display("FAIL flush_pre_level: got %0d expected 2", level1);
    end
    checks++;
    if (rd_en1 !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_rd_en: got %b expected 1", rd_en1);
    end
    sb1();
    // c4: flush while A2 is in flight and A1 is buffered; transfer ignored
    @(negedge clk);
    flush1 = 1'b1;
    #1;
    checks++;
    if (rd_en1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_rd_en: got %b expected 0", rd_en1);
    end
    exp_q.delete(0);
    exp_q.delete(0);
    // c5: everything gone, next fifo word requested
    @(negedge clk);
    flush1 = 1'b0;
    #1;
    checks++;
    if ({valid1, level1} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL flush_after: valid=%b level=%0d required 0/0", valid1, level1);
    end
    checks++;
    if (rd_en1 !== 1'b1) begin
      errors++;
      $display("FAIL flush_resume_rd_en: got %b expected 1", rd_en1);
    end
    sb1();
    drain1(10, 1'b0);
    idle1(3);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ready1 = 1'b1;
    for (int i = 0; i < 8; i++) push1(8'hE0 + 8'(i));
    #1;
    sb1();
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      #1;
      sb1();
    end
    // c4: reset; E2 buffered and E3 in flight are lost
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_en1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rd_en: got %b expected 0", rd_en1);
    end
    exp_q.delete(0);
    exp_q.delete(0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({valid1, data1, level1} !== {1'b0, 8'h00, 2'd0}) begin
      errors++;
      $display("FAIL rst_mid_after: valid=%b data=%h level=%0d required 0/00/0",
               valid1, data1, level1);
    end
    sb1();
    drain1(20, 1'b0);
    idle1(3);
  endtask

  task automatic test_latency2_single();
    @(negedge clk);
    ready2 = 1'b1;
    push2(8'h5A);
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      checks++;
      if (rd_en2 !== (c == 0)) begin
        errors++;
        $display("FAIL lat2_rd_en c=%0d: got %b expected %b", c, rd_en2, (c == 0));
      end
      checks++;
      if (valid2 !== (c == 3)) begin
        errors++;
        $display("FAIL lat2_valid c=%0d: got %b expected %b", c, valid2, (c == 3));
      end
      sb2();
    end
    checks++;
    if (exp2_q.size() != 0) begin
      errors++;
      $display("FAIL lat2_left: %0d words undelivered, expected 0", exp2_q.size());
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ready2 = 1'b1;
    for (int i = 0; i < 6; i++) push2(8'h60 + 8'(i));
    #1;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      checks++;
      if (rd_en2 !== (c < 6)) begin
        errors++;
        $display("FAIL b2b_rd_en c=%0d: got %b expected %b", c, rd_en2, (c < 6));
      end
      checks++;
      if (valid2 !== (c >= 3 && c <= 8)) begin
        errors++;
        $display("FAIL b2b_valid c=%0d: got %b expected %b", c, valid2, (c >= 3 && c <= 8));
      end
      sb2();
    end
    checks++;
    if (exp2_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_left: %0d words undelivered, expected 0", exp2_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_burst();
    test_stall();
    test_alternate();
    test_flush();
    test_reset_mid();
    test_latency2_single();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
